// File: rtl/fc_layer_ctrl_pkg.sv
//==============================================================================
// fc_layer_ctrl_pkg : shared states, layer constants and output decode. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package fc_layer_ctrl_pkg;

  localparam int FC1_IFM_DEPTH = 120;
  localparam int FC1_NEURONS   = 84;
  localparam int FC2_IFM_DEPTH = 84;
  localparam int MAC_PIPE_LAT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACCUM     = 3'd1,
    ST_BIAS      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_NEXT = 3'd4,
    ST_WRITE     = 3'd5,
    ST_START     = 3'd6
  } fc_state_e;

  typedef struct packed {
    logic busy;
    logic wm_addr_sel;
    logic ifm_sel;
    logic wm_enable_read;
    logic enable_read_fc;
    logic fc1_bias_sel;
    logic end_to_previous;
    logic ifm_enable_write_next;
    logic start_to_next;
  } ctrl_out_t;

  // Control outputs as seen while the FSM sits in state s.
  function automatic ctrl_out_t decode_outputs(input fc_state_e s);
    ctrl_out_t o;
    o      = '0;
    o.busy = (s != ST_IDLE);
    case (s)
      ST_ACCUM: begin
        o.wm_addr_sel    = 1'b1;
        o.ifm_sel        = 1'b1;
        o.wm_enable_read = 1'b1;
        o.enable_read_fc = 1'b1;
      end
      ST_BIAS: begin
        o.wm_addr_sel     = 1'b1;
        o.fc1_bias_sel    = 1'b1;
        o.end_to_previous = 1'b1;
      end
      ST_WRITE: o.ifm_enable_write_next = 1'b1;
      ST_START: o.start_to_next         = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_layer_ctrl_if.sv
//==============================================================================
// fc_layer_ctrl_if : layer handshake and weight/IFM read control bundle. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fc_layer_ctrl_if
  import fc_layer_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE_WM = $clog2(FC1_IFM_DEPTH)
);
  logic                       start_from_previous;
  logic                       end_from_next;
  logic                       wm_addr_sel;
  logic [ADDRESS_SIZE_WM-1:0] wm_address_read_current;
  logic                       wm_enable_read;
  logic                       enable_read_fc;
  logic                       ifm_sel;
  logic                       fc1_bias_sel;
  logic                       end_to_previous;
  logic                       ifm_enable_write_next;
  logic                       start_to_next;
  logic                       busy;

  modport master (
    input  start_from_previous, end_from_next,
    output wm_addr_sel, wm_address_read_current, wm_enable_read, enable_read_fc,
           ifm_sel, fc1_bias_sel, end_to_previous, ifm_enable_write_next,
           start_to_next, busy
  );

  modport slave (
    output start_from_previous, end_from_next,
    input  wm_addr_sel, wm_address_read_current, wm_enable_read, enable_read_fc,
           ifm_sel, fc1_bias_sel, end_to_previous, ifm_enable_write_next,
           start_to_next, busy
  );
endinterface

`default_nettype wire

// File: rtl/fc_next_credit.sv
//==============================================================================
// fc_next_credit : next-layer busy flag, set has priority over clear. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_next_credit (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic busy
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      busy <= 1'b0;
    else if (set)   busy <= 1'b1;
    else if (clear) busy <= 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/fc_layer_ctrl.sv
//==============================================================================
// fc_layer_ctrl : FC layer sequencer (accumulate, bias, drain, hand-off). Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_layer_ctrl
  import fc_layer_ctrl_pkg::*;
#(
  parameter int IFM_DEPTH       = FC1_IFM_DEPTH,
  parameter int ADDRESS_SIZE_WM = $clog2(IFM_DEPTH),
  parameter int PIPE_LAT        = MAC_PIPE_LAT
) (
  input  logic            clk,
  input  logic            reset,
  fc_layer_ctrl_if.master bus
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDRESS_SIZE_WM-1:0] LAST_ADDR  = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);
  localparam logic [DRAIN_W-1:0]         DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

  fc_state_e                  state, state_next;
  logic [ADDRESS_SIZE_WM-1:0] cnt, cnt_next;
  logic [DRAIN_W-1:0]         drain_cnt, drain_next;
  logic                       pending_start, pending_next;
  logic                       next_busy;
  ctrl_out_t                  outs;

  fc_next_credit u_next_credit (
    .clk   (clk),
    .reset (reset),
    .set   (outs.start_to_next),
    .clear (bus.end_from_next),
    .busy  (next_busy)
  );

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    drain_next   = drain_cnt;
    pending_next = pending_start | (bus.start_from_previous & (state != ST_IDLE));
    case (state)
      ST_IDLE: begin
        if (bus.start_from_previous || pending_start) begin
          state_next   = ST_ACCUM;
          cnt_next     = '0;
          pending_next = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (cnt == LAST_ADDR) state_next = ST_BIAS;
        else                  cnt_next   = cnt + ADDRESS_SIZE_WM'(1);
      end
      ST_BIAS: begin
        state_next = ST_DRAIN;
        drain_next = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) state_next = next_busy ? ST_WAIT_NEXT : ST_WRITE;
        else                 drain_next = drain_cnt - DRAIN_W'(1);
      end
      ST_WAIT_NEXT: begin
        if (!next_busy || bus.end_from_next) state_next = ST_WRITE;
      end
      ST_WRITE: state_next = ST_START;
      ST_START: begin
        // A queued frame launches straight from START so no cycle is lost in IDLE.
        if (bus.start_from_previous || pending_start) begin
          state_next   = ST_ACCUM;
          cnt_next     = '0;
          pending_next = 1'b0;
        end else begin
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      drain_cnt     <= '0;
      pending_start <= 1'b0;
      outs          <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      drain_cnt     <= drain_next;
      pending_start <= pending_next;
      outs          <= decode_outputs(state_next);
    end
  end

  assign bus.wm_address_read_current = cnt;
  assign bus.wm_addr_sel             = outs.wm_addr_sel;
  assign bus.ifm_sel                 = outs.ifm_sel;
  assign bus.wm_enable_read          = outs.wm_enable_read;
  assign bus.enable_read_fc          = outs.enable_read_fc;
  assign bus.fc1_bias_sel            = outs.fc1_bias_sel;
  assign bus.end_to_previous         = outs.end_to_previous;
  assign bus.ifm_enable_write_next   = outs.ifm_enable_write_next;
  assign bus.start_to_next           = outs.start_to_next;
  assign bus.busy                    = outs.busy;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_ctrl.sv
//==============================================================================
// tb_fc_layer_ctrl : random frame timelines against a timing-arithmetic model. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fc_layer_ctrl;
  import fc_layer_ctrl_pkg::*;

  localparam int D1   = FC1_IFM_DEPTH;
  localparam int P1   = MAC_PIPE_LAT;
  localparam int D2   = FC2_IFM_DEPTH;
  localparam int P2   = 1;
  localparam int MAXC = 2048;

  // {busy, wm_addr_sel, ifm_sel, wm_enable_read, enable_read_fc,
  //  fc1_bias_sel, end_to_previous, ifm_enable_write_next, start_to_next}
  localparam logic [8:0] F_IDLE  = 9'b0_0000_0000;
  localparam logic [8:0] F_BUSY  = 9'b1_0000_0000;
  localparam logic [8:0] F_ACCUM = 9'b1_1111_0000;
  localparam logic [8:0] F_BIAS  = 9'b1_1000_1100;
  localparam logic [8:0] F_WRITE = 9'b1_0000_0010;
  localparam logic [8:0] F_START = 9'b1_0000_0001;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fc_layer_ctrl_if #(.ADDRESS_SIZE_WM($clog2(D1))) bus1 ();
  fc_layer_ctrl_if #(.ADDRESS_SIZE_WM($clog2(D2))) bus2 ();

  fc_layer_ctrl dut1 (.clk(clk), .reset(reset), .bus(bus1));
  fc_layer_ctrl #(.IFM_DEPTH(D2), .PIPE_LAT(P2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0] exp_flags [MAXC];
  int         exp_addr  [MAXC];
  bit         drv_start [MAXC];
  bit         drv_end   [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] flags(input int sel);
    if (sel == 1)
      return {bus1.busy, bus1.wm_addr_sel, bus1.ifm_sel, bus1.wm_enable_read, bus1.enable_read_fc,
              bus1.fc1_bias_sel, bus1.end_to_previous, bus1.ifm_enable_write_next, bus1.start_to_next};
    return {bus2.busy, bus2.wm_addr_sel, bus2.ifm_sel, bus2.wm_enable_read, bus2.enable_read_fc,
            bus2.fc1_bias_sel, bus2.end_to_previous, bus2.ifm_enable_write_next, bus2.start_to_next};
  endfunction

  function automatic logic [31:0] addr_of(input int sel);
    if (sel == 1) return 32'(bus1.wm_address_read_current);
    return 32'(bus2.wm_address_read_current);
  endfunction

  task automatic drive(input int sel, input bit s, input bit e);
    if (sel == 1) begin
      bus1.start_from_previous = s;
      bus1.end_from_next       = e;
    end else begin
      bus2.start_from_previous = s;
      bus2.end_from_next       = e;
    end
  endtask

  // Plans a run of frames as cycle timelines, then replays the inputs and checks every cycle.
  // Input "at cycle k" is captured by edge k+1; expected values at k are those after edge k.
  task automatic run_phase(input int sel, input int nframes, input bit directed, input bit final_end);
    int d, p, c, l, w0, w, ec, lp, sxp, last;
    d   = (sel == 1) ? D1 : D2;
    p   = (sel == 1) ? P1 : P2;
    lp  = 0;
    sxp = 0;
    for (int k = 0; k < MAXC; k++) begin
      exp_flags[k] = F_IDLE;
      exp_addr[k]  = -1;
      drv_start[k] = 1'b0;
      drv_end[k]   = 1'b0;
    end
    for (int f = 0; f < nframes; f++) begin
      if (f == 0)        c = directed ? 0 : int'($urandom_range(3, 0));
      else if (directed) c = lp + d + 2;
      else               c = int'($urandom_range(sxp + 5, lp + d + 1));
      drv_start[c] = 1'b1;
      if (f > 0 && c < sxp && $urandom_range(1, 0) == 1) drv_start[c + 1] = 1'b1;
      l  = (f == 0 || c + 1 > sxp + 1) ? c + 1 : sxp + 1;
      w0 = l + d + p + 1;
      if (f == 0) begin
        w = w0;
      end else begin
        if (directed)                      ec = w0 + 7;
        else if ($urandom_range(1, 0) == 1) ec = int'($urandom_range(w0 + 6, w0 - 3));
        else                               ec = int'($urandom_range(w0 + 6, sxp + 1));
        if (directed || $urandom_range(1, 0) == 1) drv_end[sxp] = 1'b1;
        drv_end[ec] = 1'b1;
        w = (ec + 2 <= w0) ? w0 : ((ec > w0) ? ec + 1 : w0 + 1);
      end
      for (int k = l; k < l + d; k++) begin
        exp_flags[k] = F_ACCUM;
        exp_addr[k]  = k - l;
      end
      exp_flags[l + d] = F_BIAS;
      for (int k = l + d + 1; k < w; k++) exp_flags[k] = F_BUSY;
      exp_flags[w]     = F_WRITE;
      exp_flags[w + 1] = F_START;
      lp  = l;
      sxp = w + 1;
    end
    if (final_end) drv_end[sxp + 2] = 1'b1;
    last = sxp + 4;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      check_eq($sformatf("flags%0d[%0d]", sel, k), 32'(flags(sel)), 32'(exp_flags[k]));
      if (exp_addr[k] >= 0)
        check_eq($sformatf("addr%0d[%0d]", sel, k), addr_of(sel), 32'(exp_addr[k]));
      drive(sel, drv_start[k], drv_end[k]);
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_eq("reset_flags1", 32'(flags(1)), 32'(F_IDLE));
    check_eq("reset_addr1",  addr_of(1), 32'd0);
    check_eq("reset_flags2", 32'(flags(2)), 32'(F_IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single frame, next layer idle; leaves the next layer marked busy.
    run_phase(1, 1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of ACCUM at address 57.
    @(negedge clk);
    drive(1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0);
    repeat (57) @(negedge clk);
    check_eq("pre_reset_flags", 32'(flags(1)), 32'(F_ACCUM));
    check_eq("pre_reset_addr",  addr_of(1), 32'd57);
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset_flags", 32'(flags(1)), 32'(F_IDLE));
    check_eq("async_reset_addr",  addr_of(1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Credit cleared by reset, start queued in DRAIN, stall until a late end_from_next.
    run_phase(1, 2, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) run_phase(1, int'($urandom_range(5, 3)), 1'b0, 1'b1);

    run_phase(2, 1, 1'b1, 1'b1);
    run_phase(2, 3, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
